// File: rtl/tone_note_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tone_note_detector_pkg
// Description : Shared note table for the square-wave note path. It holds the
//               note codes, the class encoding (four notes plus NONE), the
//               nominal periods in CLOCK_50 cycles, the band tolerance, the
//               no-tone timeout and the lock count. The tone generator and the
//               detector both use it, so they always agree on the table.
// Revision    : 1.0 - initial release
// ============================================================================
package tone_note_detector_pkg;

    localparam int c_CNT_W      = 18;
    localparam int c_NOM_A      = 113636;   // A4, 440.00 Hz
    localparam int c_NOM_C      = 191113;   // C4, 261.63 Hz
    localparam int c_NOM_F      = 143172;   // F4, 349.23 Hz
    localparam int c_NOM_G      = 127551;   // G4, 392.00 Hz
    localparam int c_TOL        = 2048;
    localparam int c_MAX_PERIOD = 200000;
    localparam int c_MATCH_CNT  = 3;

    localparam logic [1:0] NOTE_A = 2'd0;
    localparam logic [1:0] NOTE_C = 2'd1;
    localparam logic [1:0] NOTE_F = 2'd2;
    localparam logic [1:0] NOTE_G = 2'd3;

    // The low two bits of a note class are its note code.
    typedef enum logic [2:0] {
        CLS_A    = 3'd0,
        CLS_C    = 3'd1,
        CLS_F    = 3'd2,
        CLS_G    = 3'd3,
        CLS_NONE = 3'd4
    } note_cls_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } det_state_t;

    // Inclusive band test: nom - tol <= p <= nom + tol.
    function automatic logic in_band(input int p, input int nom, input int tol);
        return (p >= nom - tol) && (p <= nom + tol);
    endfunction

    // Bands never overlap, so the order of the tests does not matter.
    function automatic note_cls_t classify(input int p,
                                           input int nom_a, input int nom_c,
                                           input int nom_f, input int nom_g,
                                           input int tol);
        note_cls_t cls;
        cls = CLS_NONE;
        if (in_band(p, nom_a, tol)) begin
            cls = CLS_A;
        end else if (in_band(p, nom_c, tol)) begin
            cls = CLS_C;
        end else if (in_band(p, nom_f, tol)) begin
            cls = CLS_F;
        end else if (in_band(p, nom_g, tol)) begin
            cls = CLS_G;
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : tone_edge_sync
// Description : Two-flop synchroniser for an asynchronous input followed by a
//               registered rising-edge detector. o_rise is a one-cycle pulse
//               that appears three clocks after i_async rises.
// Ports       : clk     in  system clock
//               rst_n   in  asynchronous active-low reset
//               i_async in  asynchronous level input
//               o_rise  out one-cycle rising-edge pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tone_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/tone_note_detector.sv
`default_nettype none
// ============================================================================
// Module      : tone_note_detector
// Description : Measures the period between rising edges of an asynchronous
//               square-wave tone and decodes it to one of the notes A, C, F, G.
//               A note is locked after MATCH_CNT consecutive periods fall in
//               the same band; a mismatched or out-of-band period drops the
//               lock, and MAX_PERIOD cycles without an edge return to IDLE.
// Ports       : CLOCK_50    in   system clock
//               RESET_N     in   asynchronous active-low reset
//               tone_in     in   asynchronous tone input
//               note_valid  out  high while locked on a note
//               note_id     out  0=A 1=C 2=F 3=G, meaningful with note_valid
//               note_strobe out  one-cycle pulse when note_valid rises
//               period_out  out  last measured period in cycles
//               period_vld  out  one-cycle pulse when period_out updates
// Revision    : 1.0 - initial release
// ============================================================================
module tone_note_detector
    import tone_note_detector_pkg::*;
#(
    parameter int CNT_W      = c_CNT_W,
    parameter int NOM_A      = c_NOM_A,
    parameter int NOM_C      = c_NOM_C,
    parameter int NOM_F      = c_NOM_F,
    parameter int NOM_G      = c_NOM_G,
    parameter int TOL        = c_TOL,
    parameter int MAX_PERIOD = c_MAX_PERIOD,
    parameter int MATCH_CNT  = c_MATCH_CNT
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             tone_in,
    output logic             note_valid,
    output logic [1:0]       note_id,
    output logic             note_strobe,
    output logic [CNT_W-1:0] period_out,
    output logic             period_vld
);

    localparam int               c_MW    = $clog2(MATCH_CNT + 1);
    localparam logic [CNT_W-1:0] c_MAX   = CNT_W'(MAX_PERIOD);
    localparam logic [c_MW-1:0]  c_MATCH = c_MW'(MATCH_CNT);

    logic             w_edge;
    logic             w_timeout;
    logic [CNT_W-1:0] r_cnt;
    note_cls_t        w_cls;
    note_cls_t        r_cls;
    note_cls_t        r_prev;
    logic             r_cls_vld;
    logic [c_MW-1:0]  r_match;
    logic [c_MW-1:0]  w_match_next;
    det_state_t       r_state;

    tone_edge_sync u_edge_sync (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .i_async (tone_in),
        .o_rise  (w_edge)
    );

    // An edge on the saturation cycle is a valid period, so it suppresses
    // the timeout.
    assign w_timeout = (r_cnt == c_MAX) && !w_edge;

    // Restarting at 1 makes the value seen on the next edge cycle equal to
    // the number of cycles between the two edges.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != c_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_cls        = classify(32'(period_out), NOM_A, NOM_C, NOM_F, NOM_G, TOL);
        w_match_next = (r_cls == r_prev) ? (r_match + c_MW'(1)) : c_MW'(1);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_prev      <= CLS_NONE;
            r_cls       <= CLS_NONE;
            r_cls_vld   <= 1'b0;
            r_match     <= '0;
            note_valid  <= 1'b0;
            note_id     <= '0;
            note_strobe <= 1'b0;
            period_out  <= '0;
            period_vld  <= 1'b0;
        end else begin
            period_vld  <= 1'b0;
            note_strobe <= 1'b0;
            r_cls_vld   <= period_vld;
            if (period_vld) begin
                r_cls <= w_cls;
            end
            // The first edge out of IDLE only opens a measurement window.
            if (w_edge && (r_state != ST_IDLE)) begin
                period_out <= r_cnt;
                period_vld <= 1'b1;
            end

            if (w_timeout) begin
                r_state    <= ST_IDLE;
                r_match    <= '0;
                note_valid <= 1'b0;
                note_id    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_edge) begin
                            r_state <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (r_cls_vld) begin
                            if (r_cls == CLS_NONE) begin
                                r_match <= '0;
                            end else begin
                                r_prev  <= r_cls;
                                r_match <= w_match_next;
                                if (w_match_next == c_MATCH) begin
                                    r_state     <= ST_LOCKED;
                                    note_valid  <= 1'b1;
                                    note_id     <= r_cls[1:0];
                                    note_strobe <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_LOCKED: begin
                        // r_prev holds the locked class while locked.
                        if (r_cls_vld && (r_cls != r_prev)) begin
                            r_state    <= ST_MEASURE;
                            note_valid <= 1'b0;
                            if (r_cls == CLS_NONE) begin
                                r_match <= '0;
                            end else begin
                                r_match <= c_MW'(1);
                                r_prev  <= r_cls;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
